multicycle_control_fsm: RTL and testbench



---
 rtl/core_ctrl_pkg.sv | 59 +++++
 rtl/imm_src_decoder.sv | 26 ++
 rtl/multicycle_control_fsm.sv | 159 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the RV32I core controllers.
// Holds the controller state encoding, the opcodes the control path
// recognises, and the select encodings driven onto the datapath
// (immediate extender, ALU operand muxes, ALU op class, result mux).
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UTYPE    = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_NONE  = 3'b000;
    localparam logic [2:0] IMM_I     = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_J     = 3'b101;
    localparam logic [2:0] IMM_ISH   = 3'b110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Immediate-extender select decoder, shared by the single-cycle and
// multicycle controllers.
// Ports: op_i (IR[6:0]), funct3_i (IR[14:12]) in; imm_src_o (extender select) out.
module imm_src_decoder
    import core_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    output logic [2:0] imm_src_o
);

    always_comb begin
        imm_src_o = IMM_NONE;
        case (op_i)
            OP_LOAD, OP_JALR: imm_src_o = IMM_I;
            // slli/srli/srai carry shamt + funct7 in the immediate field
            OP_IMM:           imm_src_o = (funct3_i == 3'b001 || funct3_i == 3'b101) ? IMM_ISH : IMM_I;
            OP_STORE:         imm_src_o = IMM_S;
            OP_BRANCH:        imm_src_o = IMM_B;
            OP_LUI, OP_AUIPC: imm_src_o = IMM_U;
            OP_JAL:           imm_src_o = IMM_J;
            default:          imm_src_o = IMM_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main controller of the multicycle RV32I core. Steps the shared datapath
// through fetch/decode/execute/writeback, waits on the memory port and
// pulses illegal on unsupported opcodes.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   op, funct3, funct7b5  fields of the latched instruction
//   zero                  ALU result == 0
//   mem_ready             memory port finished its access this cycle
//   imm_src               extender select (combinational from op/funct3)
//   ir_write, pc_write, mem_read, mem_write, reg_write   strobes
//   adr_src, alu_src_a, alu_src_b, alu_op, result_src    datapath selects
//   illegal               one-cycle pulse on an unsupported opcode
module multicycle_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] imm_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic [2:0] imm_src_dec;
    logic       irw, pcw, adr, mrd, mwr, rgw, ill;
    logic [1:0] srca, srcb, aop, res;

    // funct7b5 only matters to the ALU decoder downstream
    logic unused_funct7b5;
    assign unused_funct7b5 = funct7b5;

    imm_src_decoder u_imm_dec (
        .op_i      (op),
        .funct3_i  (funct3),
        .imm_src_o (imm_src_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        irw = 1'b0; pcw = 1'b0; adr = 1'b0; mrd = 1'b0;
        mwr = 1'b0; rgw = 1'b0; ill = 1'b0;
        srca = SRCA_PC; srcb = SRCB_RS2; aop = ALU_ADD; res = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mrd  = 1'b1;
                srca = SRCA_PC; srcb = SRCB_FOUR; aop = ALU_ADD; res = RES_ALU;
                if (mem_ready) begin
                    irw     = 1'b1;
                    pcw     = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // oldPC+imm lands in ALUOut: branch/jal target and auipc result
                srca = SRCA_OLDPC; srcb = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UTYPE;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                srca = SRCA_RS1; srcb = SRCB_IMM;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr = 1'b1; mrd = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res = RES_MEM; rgw = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                adr = 1'b1; mwr = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                srca = SRCA_RS1; srcb = SRCB_RS2; aop = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                srca = SRCA_RS1; srcb = SRCB_IMM; aop = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                res = RES_ALUOUT; rgw = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                srca = SRCA_RS1; srcb = SRCB_RS2; aop = ALU_SUB; res = RES_ALUOUT;
                pcw = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target) while the ALU forms oldPC+4 for the link write
                srca = SRCA_OLDPC; srcb = SRCB_FOUR; res = RES_ALUOUT; pcw = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                // rs1+imm is latched into ALUOut, so S_JAL then redirects to it
                srca = SRCA_RS1; srcb = SRCB_IMM;
                state_d = S_JAL;
            end
            S_UTYPE: begin
                res = (op == OP_LUI) ? RES_IMM : RES_ALUOUT;
                rgw = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                ill = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are forced quiet while reset is held so an access in flight
    // is abandoned in the same instant reset asserts.
    assign imm_src    = rst_n ? imm_src_dec : IMM_NONE;
    assign ir_write   = rst_n & irw;
    assign pc_write   = rst_n & pcw;
    assign adr_src    = rst_n & adr;
    assign mem_read   = rst_n & mrd;
    assign mem_write  = rst_n & mwr;
    assign reg_write  = rst_n & rgw;
    assign illegal    = rst_n & ill;
    assign alu_src_a  = rst_n ? srca : 2'b00;
    assign alu_src_b  = rst_n ? srcb : 2'b00;
    assign alu_op     = rst_n ? aop  : 2'b00;
    assign result_src = rst_n ? res  : 2'b00;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm. Each
// instruction is expanded into its expected per-cycle control pattern
// from the instruction class and the stall counts, then compared cycle by cycle.
module tb_multicycle_control_fsm;
    import core_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] imm_src;
    logic       ir_write, pc_write, adr_src, mem_read, mem_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

    int checks = 0;
    int failures = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .imm_src(imm_src),
        .ir_write(ir_write), .pc_write(pc_write), .adr_src(adr_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {ir_write,pc_write,adr_src,mem_read,mem_write,reg_write,a,b,aluop,res,illegal}
    logic [14:0] obs;
    assign obs = {ir_write, pc_write, adr_src, mem_read, mem_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src, illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (op=%b f3=%b)", tag, got, exp, op, funct3);
        end
    endtask

    function automatic logic [14:0] mk(bit irw, bit pcw, bit adr, bit mrd, bit mwr, bit rgw,
                                       logic [1:0] a, logic [1:0] b, logic [1:0] aop,
                                       logic [1:0] res, bit ill);
        return {irw, pcw, adr, mrd, mwr, rgw, a, b, aop, res, ill};
    endfunction

    function automatic logic [2:0] ref_imm(logic [6:0] o, logic [2:0] f3);
        case (o)
            7'b0000011, 7'b1100111: return 3'b001;
            7'b0010011:             return (f3 == 3'b001 || f3 == 3'b101) ? 3'b110 : 3'b001;
            7'b0100011:             return 3'b010;
            7'b1100011:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            7'b1101111:             return 3'b101;
            default:                return 3'b000;
        endcase
    endfunction

    // rdy: 0/1 drive that value, 2 = random (the state should ignore it)
    task automatic step(input string tag, input logic [14:0] exp, input int rdy, input bit chk_imm);
        mem_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy);
        @(negedge clk);
        chk(tag, 32'(obs), 32'(exp));
        if (chk_imm) chk({tag, "_imm"}, 32'(imm_src), 32'(ref_imm(op, funct3)));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input bit z,
                             input int fst, input int mst);
        bit taken;
        op = o; funct3 = f3; zero = z; funct7b5 = 1'($urandom_range(0, 1));
        for (int i = 0; i < fst; i++)
            step("fetch_wait", mk(0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b10, 0), 0, 0);
        step("fetch", mk(1,1,0,1,0,0, 2'b00,2'b10,2'b00,2'b10, 0), 1, 0);
        step("decode", mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0), 2, 1);
        case (o)
            7'b0000011: begin
                step("memadr", mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0), 2, 1);
                for (int i = 0; i < mst; i++)
                    step("memread_wait", mk(0,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0), 0, 1);
                step("memread", mk(0,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0), 1, 1);
                step("memwb", mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 0), 2, 1);
            end
            7'b0100011: begin
                step("memadr", mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0), 2, 1);
                for (int i = 0; i < mst; i++)
                    step("memwrite_wait", mk(0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0), 0, 1);
                step("memwrite", mk(0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0), 1, 1);
            end
            7'b0110011: begin
                step("execr", mk(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0), 2, 1);
                step("aluwb", mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0), 2, 1);
            end
            7'b0010011: begin
                step("execi", mk(0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0), 2, 1);
                step("aluwb", mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0), 2, 1);
            end
            7'b1100011: begin
                taken = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
                step("branch", mk(0,taken,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 0), 2, 1);
            end
            7'b1101111: begin
                step("jal", mk(0,1,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0), 2, 1);
                step("aluwb", mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0), 2, 1);
            end
            7'b1100111: begin
                step("jalr", mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0), 2, 1);
                step("jalr_jal", mk(0,1,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0), 2, 1);
                step("aluwb", mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0), 2, 1);
            end
            7'b0110111:
                step("lui", mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11, 0), 2, 1);
            7'b0010111:
                step("auipc", mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0), 2, 1);
            default:
                step("trap", mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1), 2, 1);
        endcase
    endtask

    logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        logic [6:0] ro;
        // reset state
        #3;
        chk("reset_ctl", 32'(obs), 32'd0);
        chk("reset_imm", 32'(imm_src), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // directed cases
        run_instr(7'b0110011, 3'b000, 0, 0, 0);   // add
        run_instr(7'b0000011, 3'b010, 0, 0, 3);   // lw, 3 wait cycles
        run_instr(7'b1100011, 3'b000, 1, 0, 0);   // beq taken
        run_instr(7'b1100011, 3'b000, 0, 0, 0);   // beq not taken
        run_instr(7'b1100011, 3'b001, 1, 0, 0);   // bne not taken
        run_instr(7'b1100011, 3'b001, 0, 0, 0);   // bne taken
        run_instr(7'b1100011, 3'b100, 1, 0, 0);   // blt: never taken here
        run_instr(7'b0010011, 3'b101, 0, 0, 0);   // srai
        run_instr(7'b0010011, 3'b001, 0, 0, 0);   // slli
        run_instr(7'b0010011, 3'b000, 0, 0, 0);   // addi
        run_instr(7'b1101111, 3'b000, 0, 1, 0);   // jal
        run_instr(7'b1100111, 3'b000, 0, 0, 0);   // jalr
        run_instr(7'b0100011, 3'b010, 0, 2, 2);   // sw with waits
        run_instr(7'b0110111, 3'b000, 0, 0, 0);   // lui
        run_instr(7'b0010111, 3'b000, 0, 0, 0);   // auipc
        run_instr(7'b1111111, 3'b000, 0, 0, 0);   // illegal

        // reset in the middle of a stalled store
        op = 7'b0100011; funct3 = 3'b010;
        step("rs_fetch", mk(1,1,0,1,0,0, 2'b00,2'b10,2'b00,2'b10, 0), 1, 0);
        step("rs_decode", mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0), 2, 1);
        step("rs_memadr", mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0), 2, 1);
        step("rs_memwrite", mk(0,0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0), 0, 1);
        mem_ready = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(obs), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold", 32'(obs), 32'd0);
        rst_n = 1'b1;
        step("post_rst_fetch", mk(0,0,0,1,0,0, 2'b00,2'b10,2'b00,2'b10, 0), 0, 0);

        // random instruction stream
        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom_range(0, 9);
            ro = (k == 9) ? 7'($urandom) : ops[k];
            run_instr(ro, 3'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
